// File: rtl/dma_rd_slice_if.sv
// Read-request channel from dma_rd_slice to axi2fifo.
interface dma_rd_slice_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 3
);
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic [7:0]            rd_req_len;
  logic [2:0]            rd_req_size;
  logic                  rd_req_last;
  logic [IDX_WIDTH-1:0]  rd_req_idx;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_len, rd_req_size, rd_req_last, rd_req_idx,
    input  rd_req_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_len, rd_req_size, rd_req_last, rd_req_idx,
    output rd_req_ready
  );
endinterface

// File: rtl/dma_rd_slice.sv
// Splits one DMA read descriptor into AXI read-burst requests (INCR bursts or jump beats).
module dma_rd_slice #(
  parameter int unsigned DMA_ADDR_WIDTH  = 32,
  parameter int unsigned DMA_DATA_WIDTH  = 64,
  parameter int unsigned DMA_BYTES_WIDTH = 32,
  parameter int unsigned DMA_NUM_DESC    = 8,
  parameter int unsigned DESC_IDX_WIDTH  = $clog2(DMA_NUM_DESC),
  parameter int unsigned MAX_BURST_LEN   = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [DESC_IDX_WIDTH-1:0]                      dma_rd_slice_idx,
  input  logic                                           dma_rd_slice_valid,
  output logic                                           dma_rd_slice_done,
  input  logic [DMA_NUM_DESC-1:0][DMA_ADDR_WIDTH-1:0]    csr_desc_src_addr,
  input  logic [DMA_NUM_DESC-1:0][DMA_BYTES_WIDTH-1:0]   csr_desc_num_bytes,
  input  logic [DMA_NUM_DESC-1:0]                        csr_desc_read_mode,
  input  logic [DMA_NUM_DESC-1:0][DMA_BYTES_WIDTH-1:0]   csr_desc_read_jump_bytes,
  dma_rd_slice_if.master                                 req_if
);

  localparam int unsigned Bpb   = DMA_DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(Bpb);
  // Two spare bits so off + rem + Bpb - 1 cannot overflow.
  localparam int unsigned CalcW = DMA_BYTES_WIDTH + 2;

  typedef enum logic [1:0] {StIdle, StCalc, StReq, StDone} state_e;

  state_e                      state_q, state_d;
  logic                        block_q, block_d;
  logic [DMA_ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [DMA_BYTES_WIDTH-1:0]  rem_q, rem_d;
  logic                        mode_q, mode_d;
  logic [DMA_BYTES_WIDTH-1:0]  jump_q, jump_d;
  logic [DESC_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                        req_valid_q, req_valid_d;
  logic [DMA_ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [7:0]                  req_len_q, req_len_d;
  logic                        req_last_q, req_last_d;
  logic [DMA_ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [DMA_BYTES_WIDTH-1:0]  next_rem_q, next_rem_d;

  logic [OffW-1:0]             off;
  logic [DMA_ADDR_WIDTH-1:0]   aligned;
  logic [11:0]                 aligned_lo;
  logic [CalcW-1:0]            beats_rem, beats_4k, beats, consumed;
  logic [DMA_ADDR_WIDTH-1:0]   calc_addr, calc_next_addr;
  logic [7:0]                  calc_len;
  logic                        calc_last;
  logic [DMA_BYTES_WIDTH-1:0]  calc_rem;

  // Next request from the current position: address, length, last flag and post-accept state.
  always_comb begin
    off        = cur_addr_q[OffW-1:0];
    aligned    = cur_addr_q & ~DMA_ADDR_WIDTH'(Bpb - 1);
    aligned_lo = aligned[11:0];
    beats_rem  = (CalcW'(off) + CalcW'(rem_q) + CalcW'(Bpb - 1)) >> OffW;
    beats_4k   = (CalcW'(4096) - CalcW'(aligned_lo)) >> OffW;
    beats      = CalcW'(MAX_BURST_LEN);
    if (beats_rem < beats) beats = beats_rem;
    if (beats_4k < beats)  beats = beats_4k;
    // A zero-byte descriptor still issues one beat.
    if (beats == '0)       beats = CalcW'(1);
    calc_addr      = aligned;
    calc_len       = 8'(beats - CalcW'(1));
    consumed       = (beats << OffW) - CalcW'(off);
    calc_next_addr = aligned + DMA_ADDR_WIDTH'(beats << OffW);
    if (mode_q) begin
      calc_addr      = cur_addr_q;
      calc_len       = 8'd0;
      consumed       = CalcW'(Bpb);
      calc_next_addr = cur_addr_q + DMA_ADDR_WIDTH'(jump_q);
    end
    calc_last = consumed >= CalcW'(rem_q);
    calc_rem  = calc_last ? '0 : (rem_q - consumed[DMA_BYTES_WIDTH-1:0]);
  end

  // FSM next-state and register updates.
  always_comb begin
    state_d     = state_q;
    block_d     = 1'b0;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    jump_d      = jump_q;
    idx_d       = idx_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    req_last_d  = req_last_q;
    next_addr_d = next_addr_q;
    next_rem_d  = next_rem_q;
    unique case (state_q)
      StIdle: begin
        // block_q skips the cycle after DONE so the upstream index update lands first.
        if (dma_rd_slice_valid && !block_q) begin
          cur_addr_d = csr_desc_src_addr[dma_rd_slice_idx];
          rem_d      = csr_desc_num_bytes[dma_rd_slice_idx];
          mode_d     = csr_desc_read_mode[dma_rd_slice_idx];
          jump_d     = csr_desc_read_jump_bytes[dma_rd_slice_idx];
          idx_d      = dma_rd_slice_idx;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        req_valid_d = 1'b1;
        req_addr_d  = calc_addr;
        req_len_d   = calc_len;
        req_last_d  = calc_last;
        next_addr_d = calc_next_addr;
        next_rem_d  = calc_rem;
        state_d     = StReq;
      end
      StReq: begin
        if (req_if.rd_req_ready) begin
          req_valid_d = 1'b0;
          cur_addr_d  = next_addr_q;
          rem_d       = next_rem_q;
          state_d     = req_last_q ? StDone : StCalc;
        end
      end
      StDone: begin
        block_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      block_q     <= 1'b0;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      mode_q      <= 1'b0;
      jump_q      <= '0;
      idx_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      req_last_q  <= 1'b0;
      next_addr_q <= '0;
      next_rem_q  <= '0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      jump_q      <= jump_d;
      idx_q       <= idx_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      req_last_q  <= req_last_d;
      next_addr_q <= next_addr_d;
      next_rem_q  <= next_rem_d;
    end
  end

  assign dma_rd_slice_done   = (state_q == StDone);
  assign req_if.rd_req_valid = req_valid_q;
  assign req_if.rd_req_addr  = req_addr_q;
  assign req_if.rd_req_len   = req_len_q;
  assign req_if.rd_req_size  = 3'(OffW);
  assign req_if.rd_req_last  = req_last_q;
  assign req_if.rd_req_idx   = idx_q;

endmodule
